gcd_datapath: RTL and testbench

- Register-transfer datapath for a subtractive GCD engine (FSMD). Sits under an external controller FSM.
- Holds operand registers X and Y and result register D.
- Supplies comparison status (x_neq_y, x_lt_y) to the controller and executes the controller's load/select commands.
- All arithmetic is unsigned, WIDTH bits.

---
 rtl/gcd_datapath.sv | 128 ++++++++++++
 tb/tb_gcd_datapath.sv | 130 +++++++++++++
 2 files changed

// File: rtl/gcd_datapath.sv
// Subtractive GCD datapath: operand registers X/Y, result register D, two wrap-around
// subtractors and a comparator pair feeding status back to an external controller.

module gcd_sub #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] diff_o
);
   // Modulo-2^WIDTH difference; the borrow is intentionally discarded.
   always_comb begin
      diff_o = a_i - b_i;
   end
endmodule

module gcd_mux2 #(
   parameter int WIDTH = 4
) (
   input  logic             sel_i,
   input  logic [WIDTH-1:0] in0_i,
   input  logic [WIDTH-1:0] in1_i,
   output logic [WIDTH-1:0] out_o
);
   // Two-way operand select.
   always_comb begin
      if (sel_i) begin
         out_o = in1_i;
      end else begin
         out_o = in0_i;
      end
   end
endmodule

module gcd_ld_reg #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ld_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] q_o
);
   logic [WIDTH-1:0] val_d;
   logic [WIDTH-1:0] val_q;

   // Next value: load or hold.
   always_comb begin
      if (ld_i) begin
         val_d = din_i;
      end else begin
         val_d = val_q;
      end
   end

   // Storage with synchronous active-low clear that wins over the load enable.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         val_q <= {WIDTH{1'b0}};
      end else begin
         val_q <= val_d;
      end
   end

   assign q_o = val_q;
endmodule

module gcd_cmp #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             neq_o,
   output logic             lt_o
);
   // Unsigned status for the controller; both low when operands match.
   always_comb begin
      neq_o = (a_i != b_i);
      lt_o  = (a_i < b_i);
   end
endmodule

module gcd_datapath #(
   parameter int WIDTH = 4
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [WIDTH-1:0] x_i,
   input  logic [WIDTH-1:0] y_i,
   input  logic             x_sel,
   input  logic             x_ld,
   input  logic             y_sel,
   input  logic             y_ld,
   input  logic             d_ld,
   output logic             x_neq_y,
   output logic             x_lt_y,
   output logic [WIDTH-1:0] d_o
);
   logic [WIDTH-1:0] x_q;
   logic [WIDTH-1:0] y_q;
   logic [WIDTH-1:0] d_q;
   logic [WIDTH-1:0] x_diff_s;
   logic [WIDTH-1:0] y_diff_s;
   logic [WIDTH-1:0] x_d;
   logic [WIDTH-1:0] y_d;

   // Both subtractors read pre-edge X and Y, so simultaneous loads are a parallel transfer.
   gcd_sub #(.WIDTH(WIDTH)) u_sub_x (.a_i(x_q), .b_i(y_q), .diff_o(x_diff_s));
   gcd_sub #(.WIDTH(WIDTH)) u_sub_y (.a_i(y_q), .b_i(x_q), .diff_o(y_diff_s));

   gcd_mux2 #(.WIDTH(WIDTH)) u_mux_x (.sel_i(x_sel), .in0_i(x_i), .in1_i(x_diff_s), .out_o(x_d));
   gcd_mux2 #(.WIDTH(WIDTH)) u_mux_y (.sel_i(y_sel), .in0_i(y_i), .in1_i(y_diff_s), .out_o(y_d));

   gcd_ld_reg #(.WIDTH(WIDTH)) u_reg_x (
      .clk(CLK), .rst_n(RESET), .ld_i(x_ld), .din_i(x_d), .q_o(x_q)
   );
   gcd_ld_reg #(.WIDTH(WIDTH)) u_reg_y (
      .clk(CLK), .rst_n(RESET), .ld_i(y_ld), .din_i(y_d), .q_o(y_q)
   );
   // D captures the old X even when X is loaded on the same edge.
   gcd_ld_reg #(.WIDTH(WIDTH)) u_reg_d (
      .clk(CLK), .rst_n(RESET), .ld_i(d_ld), .din_i(x_q), .q_o(d_q)
   );

   gcd_cmp #(.WIDTH(WIDTH)) u_cmp (.a_i(x_q), .b_i(y_q), .neq_o(x_neq_y), .lt_o(x_lt_y));

   assign d_o = d_q;
endmodule

// File: tb/tb_gcd_datapath.sv
// Directed plus random bench for gcd_datapath; expected register state is queued when
// commands are driven and popped after the edge for comparison.

module tb_gcd_datapath;
   localparam int WIDTH = 4;

   logic             CLK = 1'b0;
   logic             RESET;
   logic [WIDTH-1:0] x_i, y_i;
   logic             x_sel, x_ld, y_sel, y_ld, d_ld;
   logic             x_neq_y, x_lt_y;
   logic [WIDTH-1:0] d_o;

   typedef struct packed {
      logic [WIDTH-1:0] x;
      logic [WIDTH-1:0] y;
      logic [WIDTH-1:0] d;
   } exp_t;

   exp_t             sb_q[$];
   logic [WIDTH-1:0] mx, my, md;
   int               n_checks = 0;
   int               n_fail   = 0;

   gcd_datapath #(.WIDTH(WIDTH)) dut (
      .CLK(CLK), .RESET(RESET), .x_i(x_i), .y_i(y_i),
      .x_sel(x_sel), .x_ld(x_ld), .y_sel(y_sel), .y_ld(y_ld), .d_ld(d_ld),
      .x_neq_y(x_neq_y), .x_lt_y(x_lt_y), .d_o(d_o)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   // Drive one cycle of commands, model the edge, then compare after it.
   task automatic step(input logic rst, input logic xs, input logic xl, input logic ys,
                       input logic yl, input logic dl, input logic [WIDTH-1:0] xi,
                       input logic [WIDTH-1:0] yi);
      exp_t             e;
      logic [WIDTH-1:0] nx, ny, nd;
      RESET = rst; x_sel = xs; x_ld = xl; y_sel = ys; y_ld = yl; d_ld = dl;
      x_i = xi; y_i = yi;
      if (!rst) begin
         nx = '0; ny = '0; nd = '0;
      end else begin
         nx = xl ? (xs ? WIDTH'(mx - my) : xi) : mx;
         ny = yl ? (ys ? WIDTH'(my - mx) : yi) : my;
         nd = dl ? mx : md;
      end
      mx = nx; my = ny; md = nd;
      e.x = nx; e.y = ny; e.d = nd;
      sb_q.push_back(e);
      @(posedge CLK);
      #1;
      if (sb_q.size() == 0) begin
         chk("scoreboard_empty", 8'd1, 8'd0);
      end else begin
         e = sb_q.pop_front();
         chk("x_reg",   {4'd0, dut.x_q}, {4'd0, e.x});
         chk("y_reg",   {4'd0, dut.y_q}, {4'd0, e.y});
         chk("d_o",     {4'd0, d_o},     {4'd0, e.d});
         chk("x_neq_y", {7'd0, x_neq_y}, {7'd0, (e.x != e.y)});
         chk("x_lt_y",  {7'd0, x_lt_y},  {7'd0, (e.x < e.y)});
      end
   endtask

   initial begin
      mx = '0; my = '0; md = '0;
      RESET = 1'b0; x_sel = 1'b0; x_ld = 1'b0; y_sel = 1'b0; y_ld = 1'b0; d_ld = 1'b0;
      x_i = '0; y_i = '0;
      @(negedge CLK);

      // Reset overrides all loads for two edges.
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd9, 4'd3);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd9, 4'd3);
      chk("tp_reset_d", {4'd0, d_o}, 8'd0);
      chk("tp_reset_neq", {7'd0, x_neq_y}, 8'd0);

      // Load 8/12, then hold.
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd8, 4'd12);
      chk("tp_load_lt", {7'd0, x_lt_y}, 8'd1);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 4'd2);

      // GCD(8,12): Y-=X, X-=Y, D<=X.
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0);
      chk("tp_gcd_y", {4'd0, dut.y_q}, 8'd4);
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
      chk("tp_gcd_eq", {7'd0, x_neq_y}, 8'd0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
      chk("tp_gcd_d", {4'd0, d_o}, 8'd4);

      // Parallel subtract with wrap: 6,4 -> 2,14.
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd6, 4'd4);
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0);
      chk("tp_par_x", {4'd0, dut.x_q}, 8'd2);
      chk("tp_par_y", {4'd0, dut.y_q}, 8'd14);

      // D takes old X when X loads on the same edge.
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd5, 4'd0);
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd7, 4'd0);
      chk("tp_dtim_d", {4'd0, d_o}, 8'd5);
      chk("tp_dtim_x", {4'd0, dut.x_q}, 8'd7);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
      chk("tp_dtim_hold", {4'd0, d_o}, 8'd5);

      // Reach X=8,Y=12,D=4, then reset mid-operation.
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd4, 4'd0);
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd8, 4'd12);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0);
      chk("tp_mid_rst_d", {4'd0, d_o}, 8'd0);
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 4'd0);
      chk("tp_mid_rst_x", {4'd0, dut.x_q}, 8'd3);

      // Random command mix.
      for (int i = 0; i < 40; i++) begin
         step(($urandom_range(0, 15) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
